syncvar_parity_check: RTL and testbench
=======================================

Name: syncvar_parity_check

Overview:
- Receive-side checker for the 2-bit symbol parity stream.
- The upstream producer sends frames of FRAME_LEN 2-bit data symbols, then one trailer symbol. The trailer carries a marker bit and the XOR parity of every data bit in the frame.
- This block recomputes the parity, checks the trailer, raises per-frame status pulses and keeps frame and error statistics.
- It sits directly downstream of the symbol register stage, in the same clock domain.

Parameters:
- FRAME_LEN, 4: data symbols per frame, excluding the trailer. Legal range is 1..255.
- CNT_W, 8: width of frame_count and err_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  a symbol is presented on in_data.
- in_data  input  2  data symbol, or trailer {marker, parity}.
- in_ready  output  1  block can accept a symbol this cycle.
- frame_done  output  1  one-cycle pulse when a frame has been checked.
- parity_err  output  1  one-cycle pulse, valid with frame_done: parity mismatch.
- frame_err  output  1  one-cycle pulse, valid with frame_done: trailer marker bit is 0.
- frame_count  output  CNT_W  number of completed frames; wraps.
- err_count  output  CNT_W  number of frames with any error; saturates.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-low (rst_n).
- Handshake:
  - A symbol is accepted on a rising edge where in_valid && in_ready.
  - in_data is ignored when not accepted.
  - in_valid may drop at any time; gaps do not affect the frame state.
- State machine: COLLECT, TRAILER, REPORT.
- COLLECT:
  - in_ready=1.
  - On accept: acc <= acc ^ in_data[1] ^ in_data[0], and sym_cnt increments.
  - When the accepted symbol is number FRAME_LEN, go to TRAILER.
- TRAILER:
  - in_ready=1.
  - On accept:
    - perr = (in_data[0] != acc);
    - ferr = (in_data[1] == 0);
    - go to REPORT.
- REPORT:
  - Lasts exactly one cycle; in_ready=0.
  - frame_done=1; parity_err=perr; frame_err=ferr.
  - frame_count and err_count already show their updated values in this cycle.
  - acc and sym_cnt are cleared; next state is COLLECT.
- Latency: trailer accepted at edge N gives frame_done high during cycle N..N+1. The next symbol can be accepted at edge N+2 at the earliest.
- Counters:
  - frame_count increments by 1 per frame and wraps from 2^CNT_W-1 to 0.
  - err_count increments by 1 per frame when (perr | ferr), i.e. a frame with both errors counts once.
  - err_count saturates at 2^CNT_W-1.
- Output registers: all outputs are registered except in_ready, which is decoded from the state.
- Reset values (rst_n=0 at a rising edge):
  - state=COLLECT; acc=0; sym_cnt=0.
  - frame_done=0, parity_err=0, frame_err=0.
  - frame_count=0, err_count=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-frame discards the partial frame: no frame_done, no counter change.
- FRAME_LEN=1: one data symbol, then the trailer.
- The producer is responsible for frame alignment. There is no resynchronisation: the trailer is always the (FRAME_LEN+1)th accepted symbol.

Optional Feature:
- Macro: SYNCVAR_STICKY_ERR_EN.
- Defined:
  - Adds input err_clr (1 bit) and output err_sticky (1 bit, reset 0).
  - err_sticky sets in the same cycle frame_done asserts with perr|ferr, i.e. visible in the REPORT cycle.
  - err_sticky stays set until err_clr=1 at a rising edge.
  - If clear and set happen in the same cycle, set wins.
- Not defined: neither port exists. All other behaviour is identical.

Test Plan:
- Good frame (FRAME_LEN=4):
  - Stimulus: 01,10,11,00 then trailer 10.
  - Response: one cycle after the trailer, frame_done=1, parity_err=0, frame_err=0, frame_count=1, err_count=0; in_ready=0 in that cycle only.
- Parity error:
  - Stimulus: same data, trailer 11.
  - Response: parity_err=1, frame_err=0, err_count=1.
- Marker error with parity also wrong:
  - Stimulus: data 01,00,00,00, trailer 00.
  - Response: frame_err=1, parity_err=1, err_count incremented by exactly 1.
- Handshake gaps:
  - Stimulus: the good frame with in_valid low for 3 cycles between each symbol, and in_valid held high during REPORT.
  - Response: identical results; the symbol held during REPORT is accepted at the next edge as data symbol 1.
- Saturation and wrap (CNT_W=2):
  - Stimulus: 5 frames with parity errors.
  - Response: err_count=3 and frame_count=1 (wrapped).
- Reset mid-frame, with the macro defined:
  - Stimulus: 2 symbols, then rst_n=0 for 1 cycle, then a good frame.
  - Response: counters=0 after reset; frame_done only after the new frame; err_sticky=0.
  - Follow-up: a bad frame sets err_sticky; err_clr=1 clears it on the next edge.

Source files
------------

// File: rtl/syncvar_parity_check.sv
// Frame parity checker: FRAME_LEN data symbols then a {marker,parity} trailer; status 1 cycle after trailer.
// in_ready drops only in the one-cycle REPORT state; SYNCVAR_STICKY_ERR_EN adds err_clr/err_sticky.
module syncvar_parity_check #(
   parameter int FRAME_LEN = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [1:0]       in_data,
   output logic             in_ready,
   output logic             frame_done,
   output logic             parity_err,
   output logic             frame_err,
   output logic [CNT_W-1:0] frame_count,
   output logic [CNT_W-1:0] err_count
`ifdef SYNCVAR_STICKY_ERR_EN
   ,
   input  logic             err_clr,
   output logic             err_sticky
`endif
);

   localparam logic [1:0] COLLECT = 2'd0;
   localparam logic [1:0] TRAILER = 2'd1;
   localparam logic [1:0] REPORT  = 2'd2;

   localparam logic [7:0]       LAST_SYM = 8'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [1:0] state;
   logic       acc;
   logic [7:0] sym_cnt;
   logic       accept;
   logic       perr;
   logic       ferr;
   logic       trl_accept;

   assign in_ready   = (state != REPORT);
   assign accept     = in_valid && in_ready;
   assign perr       = (in_data[0] != acc);
   assign ferr       = ~in_data[1];
   assign trl_accept = accept && (state == TRAILER);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= COLLECT;
         acc         <= 1'b0;
         sym_cnt     <= 8'd0;
         frame_done  <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         frame_count <= '0;
         err_count   <= '0;
      end else begin
         frame_done <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            COLLECT: begin
               if (accept) begin
                  acc     <= acc ^ in_data[1] ^ in_data[0];
                  sym_cnt <= sym_cnt + 8'd1;
                  if (sym_cnt == LAST_SYM) begin
                     state <= TRAILER;
                  end
               end
            end
            TRAILER: begin
               // Counters update on the trailer edge so they are already current while frame_done is high.
               if (accept) begin
                  frame_done  <= 1'b1;
                  parity_err  <= perr;
                  frame_err   <= ferr;
                  frame_count <= frame_count + 1'b1;
                  if ((perr || ferr) && (err_count != CNT_MAX)) begin
                     err_count <= err_count + 1'b1;
                  end
                  state <= REPORT;
               end
            end
            REPORT: begin
               acc     <= 1'b0;
               sym_cnt <= 8'd0;
               state   <= COLLECT;
            end
            default: begin
               acc     <= 1'b0;
               sym_cnt <= 8'd0;
               state   <= COLLECT;
            end
         endcase
      end
   end

`ifdef SYNCVAR_STICKY_ERR_EN
   // A new error outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
      end else if (trl_accept && (perr || ferr)) begin
         err_sticky <= 1'b1;
      end else if (err_clr) begin
         err_sticky <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_syncvar_parity_check.sv
// Bench for syncvar_parity_check: FRAME_LEN=4 with CNT_W 8 and 2 side by side, plus a FRAME_LEN=1 instance.
module tb_syncvar_parity_check;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [1:0] in_data;
   logic       c_valid;
   logic [1:0] c_data;

   logic       a_in_ready, a_frame_done, a_parity_err, a_frame_err;
   logic [7:0] a_frame_count, a_err_count;
   logic       b_in_ready, b_frame_done, b_parity_err, b_frame_err;
   logic [1:0] b_frame_count, b_err_count;
   logic       c_in_ready, c_frame_done, c_parity_err, c_frame_err;
   logic [7:0] c_frame_count, c_err_count;
`ifdef SYNCVAR_STICKY_ERR_EN
   logic       err_clr;
   logic       a_sticky, b_sticky, c_sticky;
`endif

   always #5 clk = ~clk;

   syncvar_parity_check #(.FRAME_LEN(4), .CNT_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
      .frame_done(a_frame_done), .parity_err(a_parity_err), .frame_err(a_frame_err),
      .frame_count(a_frame_count), .err_count(a_err_count)
`ifdef SYNCVAR_STICKY_ERR_EN
      , .err_clr(err_clr), .err_sticky(a_sticky)
`endif
   );

   syncvar_parity_check #(.FRAME_LEN(4), .CNT_W(2)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
      .frame_done(b_frame_done), .parity_err(b_parity_err), .frame_err(b_frame_err),
      .frame_count(b_frame_count), .err_count(b_err_count)
`ifdef SYNCVAR_STICKY_ERR_EN
      , .err_clr(err_clr), .err_sticky(b_sticky)
`endif
   );

   syncvar_parity_check #(.FRAME_LEN(1), .CNT_W(8)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_data(c_data), .in_ready(c_in_ready),
      .frame_done(c_frame_done), .parity_err(c_parity_err), .frame_err(c_frame_err),
      .frame_count(c_frame_count), .err_count(c_err_count)
`ifdef SYNCVAR_STICKY_ERR_EN
      , .err_clr(err_clr), .err_sticky(c_sticky)
`endif
   );

   int n_pass = 0;
   int n_chk  = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   typedef struct {
      logic       perr;
      logic       ferr;
      logic [7:0] fc8;
      logic [7:0] ec8;
      logic [1:0] fc2;
      logic [1:0] ec2;
      int         due;
   } exp_t;

   typedef struct {
      logic [1:0] s1, s2, s3, s4;
      logic [1:0] trl;
      int         gap;
      logic       perr;
      logic       ferr;
   } vec_t;

   exp_t       sbq[$];
   logic [7:0] m_fc8, m_ec8;
   logic [1:0] m_fc2, m_ec2;

   function automatic vec_t mkvec(input logic [1:0] s1, s2, s3, s4, trl, input int gap,
                                  input logic perr, ferr);
      vec_t v;
      v.s1 = s1; v.s2 = s2; v.s3 = s3; v.s4 = s4;
      v.trl = trl; v.gap = gap; v.perr = perr; v.ferr = ferr;
      return v;
   endfunction

   task automatic model_clear();
      m_fc8 = 8'd0; m_ec8 = 8'd0; m_fc2 = 2'd0; m_ec2 = 2'd0;
   endtask

   task automatic push_exp(input logic perr, input logic ferr);
      exp_t e;
      m_fc8 = m_fc8 + 8'd1;
      m_fc2 = m_fc2 + 2'd1;
      if (perr || ferr) begin
         if (m_ec8 != 8'hff) m_ec8 = m_ec8 + 8'd1;
         if (m_ec2 != 2'h3)  m_ec2 = m_ec2 + 2'd1;
      end
      e.perr = perr; e.ferr = ferr;
      e.fc8 = m_fc8; e.ec8 = m_ec8; e.fc2 = m_fc2; e.ec2 = m_ec2;
      e.due = cyc;
      sbq.push_back(e);
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that accepted d.
   task automatic send(input logic [1:0] d, input int gap);
      bit rdy;
      int k;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      rdy = 1'b0;
      k = 0;
      while (!rdy && k < 50) begin
         @(negedge clk);
         rdy = a_in_ready;
         @(posedge clk);
         #1;
         k++;
      end
      if (!rdy) chk("accept_timeout", 0, 1);
   endtask

   task automatic frame(input vec_t v);
      send(v.s1, 0);
      send(v.s2, v.gap);
      send(v.s3, v.gap);
      send(v.s4, v.gap);
      send(v.trl, v.gap);
      push_exp(v.perr, v.ferr);
   endtask

   task automatic csend(input logic [1:0] d);
      bit rdy;
      int k;
      c_valid = 1'b1;
      c_data  = d;
      rdy = 1'b0;
      k = 0;
      while (!rdy && k < 50) begin
         @(negedge clk);
         rdy = c_in_ready;
         @(posedge clk);
         #1;
         k++;
      end
      if (!rdy) chk("c_accept_timeout", 0, 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_clear();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1) begin
         if (a_frame_done || b_frame_done) begin
            if (sbq.size() == 0) begin
               chk("stray_frame_done", 1, 0);
            end else begin
               e = sbq.pop_front();
               chk("done_cycle",    cyc,           e.due);
               chk("a_frame_done",  a_frame_done,  1);
               chk("b_frame_done",  b_frame_done,  1);
               chk("a_parity_err",  a_parity_err,  e.perr);
               chk("a_frame_err",   a_frame_err,   e.ferr);
               chk("b_parity_err",  b_parity_err,  e.perr);
               chk("b_frame_err",   b_frame_err,   e.ferr);
               chk("a_frame_count", a_frame_count, e.fc8);
               chk("a_err_count",   a_err_count,   e.ec8);
               chk("b_frame_count", b_frame_count, e.fc2);
               chk("b_err_count",   b_err_count,   e.ec2);
               chk("report_ready",  a_in_ready,    0);
            end
         end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
            chk("missing_frame_done", 0, 1);
            void'(sbq.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   vec_t tbl[7];

   initial begin
      tbl[0] = mkvec(2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 0, 1'b0, 1'b0);
      tbl[1] = mkvec(2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 0, 1'b1, 1'b0);
      tbl[2] = mkvec(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1'b1, 1'b1);
      tbl[3] = mkvec(2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 3, 1'b0, 1'b0);
      tbl[4] = mkvec(2'b10, 2'b00, 2'b00, 2'b00, 2'b11, 0, 1'b0, 1'b0);
      tbl[5] = mkvec(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b1);
      tbl[6] = mkvec(2'b11, 2'b11, 2'b01, 2'b10, 2'b01, 0, 1'b1, 1'b1);

      rst_n = 1'b0; in_valid = 1'b0; in_data = 2'b00; c_valid = 1'b0; c_data = 2'b00;
`ifdef SYNCVAR_STICKY_ERR_EN
      err_clr = 1'b0;
`endif
      model_clear();
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",    a_in_ready,    1);
      chk("rst_frame_done",  a_frame_done,  0);
      chk("rst_parity_err",  a_parity_err,  0);
      chk("rst_frame_err",   a_frame_err,   0);
      chk("rst_frame_count", a_frame_count, 0);
      chk("rst_err_count",   a_err_count,   0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Back-to-back frames; the one after a frame keeps in_valid high through REPORT.
      for (int i = 0; i < 7; i++) frame(tbl[i]);
      idle(3);
      chk("tbl_frame_count", a_frame_count, 7);
      chk("tbl_err_count",   a_err_count,   4);
      chk("tbl_b_frame_count", b_frame_count, 3);
      chk("tbl_b_err_count",   b_err_count,   3);

      // Saturation and wrap on the CNT_W=2 instance.
      do_reset();
      @(negedge clk);
      chk("rst2_a_frame_count", a_frame_count, 0);
      chk("rst2_b_err_count",   b_err_count,   0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) frame(mkvec(2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 0, 1'b1, 1'b0));
      idle(3);
      chk("sat_b_err_count",   b_err_count,   3);
      chk("sat_b_frame_count", b_frame_count, 1);
      chk("sat_a_err_count",   a_err_count,   5);
      chk("sat_a_frame_count", a_frame_count, 5);

      // Reset in the middle of a frame drops the partial frame.
      send(2'b01, 0);
      send(2'b10, 0);
      in_valid = 1'b0;
      do_reset();
      @(negedge clk);
      chk("mid_rst_frame_count", a_frame_count, 0);
      chk("mid_rst_err_count",   a_err_count,   0);
      chk("mid_rst_frame_done",  a_frame_done,  0);
      @(posedge clk);
      #1;
      frame(tbl[0]);
      idle(3);
      chk("post_rst_frame_count", a_frame_count, 1);
      chk("post_rst_err_count",   a_err_count,   0);
`ifdef SYNCVAR_STICKY_ERR_EN
      chk("sticky_clean", a_sticky, 0);
      frame(tbl[1]);
      in_valid = 1'b0;
      @(negedge clk);
      chk("sticky_set_in_report", a_sticky, 1);
      @(posedge clk);
      #1;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      @(negedge clk);
      chk("sticky_cleared", a_sticky, 0);
      @(posedge clk);
      #1;
      err_clr = 1'b1;
      frame(tbl[2]);
      in_valid = 1'b0;
      @(negedge clk);
      chk("sticky_set_wins", a_sticky, 1);
      err_clr = 1'b0;
      idle(3);
      chk("sticky_holds", a_sticky, 1);
`endif

      // FRAME_LEN=1: one data symbol then the trailer.
      csend(2'b01);
      csend(2'b11);
      c_valid = 1'b0;
      @(negedge clk);
      chk("c_frame_done",   c_frame_done,  1);
      chk("c_parity_ok",    c_parity_err,  0);
      chk("c_frame_ok",     c_frame_err,   0);
      chk("c_frame_count",  c_frame_count, 1);
      chk("c_report_ready", c_in_ready,    0);
      @(posedge clk);
      #1;
      csend(2'b10);
      csend(2'b10);
      c_valid = 1'b0;
      @(negedge clk);
      chk("c_frame_done2",  c_frame_done,  1);
      chk("c_parity_err",   c_parity_err,  1);
      chk("c_err_count",    c_err_count,   1);
      chk("c_frame_count2", c_frame_count, 2);
      @(negedge clk);
      chk("c_done_pulse",   c_frame_done,  0);

      idle(5);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
